// File: rtl/display_scan_mux8.sv
// 8-digit time-multiplexed LED scanner: per-digit registers, scan counter,
// 2:1 mux tree selection, active-low COM decode and a/g/d stroke decode.
module display_scan_mux8 #(
    parameter int SCAN_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ce,
    input  logic [31:0] din,
    output logic [2:0]  digit_sel,
    output logic [3:0]  digit_out,
    output logic [7:0]  com,
    output logic        seg_a,
    output logic        seg_g,
    output logic        seg_d
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [3:0]    dig_q [8];

    always_comb begin
        presc_d = presc_q + PW'(1);
        cnt_d   = cnt_q;
        if (presc_q == PMAX) begin
            presc_d = '0;
            cnt_d   = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

    for (genvar k = 0; k < 8; k++) begin : g_dig
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                dig_q[k] <= 4'h0;
            end else if (ce[k]) begin
                dig_q[k] <= din[4*k +: 4];
            end
        end
    end

    function automatic logic [3:0] mux2(
        input logic [3:0] s0,
        input logic [3:0] s1,
        input logic       sel
    );
        return sel ? s1 : s0;
    endfunction

    // Layer 1 on Q0, layer 2 on Q1, layer 3 on Q2
    logic [3:0] l1 [4];
    logic [3:0] l2 [2];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            l1[i] = mux2(dig_q[2*i], dig_q[2*i+1], cnt_q[0]);
        end
        for (int i = 0; i < 2; i++) begin
            l2[i] = mux2(l1[2*i], l1[2*i+1], cnt_q[1]);
        end
        digit_out = mux2(l2[0], l2[1], cnt_q[2]);
    end

    assign digit_sel = cnt_q;
    assign com       = ~(8'b1 << cnt_q);
    assign seg_a     = (digit_out[1:0] == 2'b01);
    assign seg_g     = (digit_out[1:0] == 2'b10);
    assign seg_d     = (digit_out[1:0] == 2'b11);

endmodule

// File: tb/tb_display_scan_mux8.sv
// Scoreboard bench for display_scan_mux8 at SCAN_DIV = 1 and SCAN_DIV = 3.
module tb_display_scan_mux8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ce = 8'h00;
    logic [31:0] din = 32'h0;

    logic [2:0] sel1, sel3;
    logic [3:0] dout1, dout3;
    logic [7:0] com1, com3;
    logic       a1, g1, d1, a3, g3, d3;

    always #5 clk = ~clk;

    display_scan_mux8 #(.SCAN_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .din(din),
        .digit_sel(sel1), .digit_out(dout1), .com(com1),
        .seg_a(a1), .seg_g(g1), .seg_d(d1)
    );

    display_scan_mux8 #(.SCAN_DIV(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .din(din),
        .digit_sel(sel3), .digit_out(dout3), .com(com3),
        .seg_a(a3), .seg_g(g3), .seg_d(d3)
    );

    typedef struct packed {
        logic [2:0] sel;
        logic [3:0] dout;
        logic [7:0] com;
        logic [2:0] seg;
    } obs_t;

    typedef struct packed {
        obs_t o1;
        obs_t o3;
    } exp_t;

    exp_t q[$];
    event pushed;
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference state kept by the bench
    logic [2:0] m_sel1 = 3'd0;
    logic [2:0] m_sel3 = 3'd0;
    int         m_p3 = 0;
    logic [3:0] m_reg [8];
    logic [2:0] segtab [4];

    function automatic obs_t expect_for(input logic [2:0] s, input logic [3:0] v);
        obs_t o;
        o.sel  = s;
        o.dout = v;
        o.com  = ~(8'b1 << s);
        o.seg  = segtab[v[1:0]];
        return o;
    endfunction

    task automatic push_exp();
        exp_t e;
        e.o1 = expect_for(m_sel1, m_reg[m_sel1]);
        e.o3 = expect_for(m_sel3, m_reg[m_sel3]);
        q.push_back(e);
        ->pushed;
    endtask

    task automatic model_reset();
        m_sel1 = 3'd0;
        m_sel3 = 3'd0;
        m_p3   = 0;
        for (int k = 0; k < 8; k++) m_reg[k] = 4'h0;
    endtask

    // Advance one clock, update the reference, queue the expectation
    task automatic tick();
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_sel1 = m_sel1 + 3'd1;
            if (m_p3 == 2) begin
                m_p3   = 0;
                m_sel3 = m_sel3 + 3'd1;
            end else begin
                m_p3++;
            end
            for (int k = 0; k < 8; k++)
                if (ce[k]) m_reg[k] = din[4*k +: 4];
        end
        push_exp();
    endtask

    task automatic chk(input string nm, input logic [17:0] act, input logic [17:0] exq);
        n_chk++;
        if (act !== exq) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exq);
        end
    endtask

    // Monitor: compares each queued expectation against the live outputs
    initial begin
        exp_t e;
        obs_t a;
        forever begin
            @(pushed);
            #2;
            while (q.size() > 0) begin
                e = q.pop_front();
                a = {sel1, dout1, com1, a1, g1, d1};
                chk("dut1.digit_sel", 18'(a.sel), 18'(e.o1.sel));
                chk("dut1.digit_out", 18'(a.dout), 18'(e.o1.dout));
                chk("dut1.com", 18'(a.com), 18'(e.o1.com));
                chk("dut1.seg_agd", 18'(a.seg), 18'(e.o1.seg));
                a = {sel3, dout3, com3, a3, g3, d3};
                chk("dut3.outputs", a, e.o3);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        segtab[0] = 3'b000;
        segtab[1] = 3'b100;
        segtab[2] = 3'b010;
        segtab[3] = 3'b001;
        model_reset();

        // Reset held with loads requested: all must stay zero
        rst_n = 1'b0;
        ce    = 8'hFF;
        din   = 32'hFFFF_FFFF;
        #2;
        push_exp();
        repeat (3) tick();
        ce    = 8'h00;
        rst_n = 1'b1;

        // Full scan walk with nothing loaded (sel 1..7,0,1)
        repeat (9) tick();

        // Load all digits, then change din with ce low
        ce  = 8'hFF;
        din = 32'h7654_3210;
        tick();
        ce  = 8'h00;
        din = 32'hAAAA_AAAA;
        repeat (8) tick();

        // Selective load of digit 2 only
        ce  = 8'b0000_0100;
        din = 32'h1111_1311;
        tick();
        ce  = 8'h00;
        repeat (8) tick();

        // Upper bits ignored by the stroke decode
        ce  = 8'hFF;
        din = 32'hFEDC_BA98;
        tick();
        ce  = 8'h00;
        repeat (8) tick();

        // Asynchronous reset while digit 5 is scanned
        for (int i = 0; i < 8 && m_sel1 != 3'd5; i++) tick();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        push_exp();
        tick();
        rst_n = 1'b1;
        repeat (6) tick();

        @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scan_mux8.md
Name: display_scan_mux8

Overview:
- 8-digit time-multiplexed display scanner for the 8-COM LED display.
- Holds eight 4-bit digit registers, each with its own clock enable, and cycles a 3-bit scan counter over them.
- Drives the selected digit value, a one-hot active-low COM select, and three 7-segment strokes (a, g, d) decoded from the digit's low 2 bits.
- Sits between game logic (supplies per-digit codes) and the display pins.

Parameters:
- SCAN_DIV, 1, clock cycles per scan step; integer >= 1; 1 = counter advances every clk.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ce  in  8  per-digit register clock enable; ce[k] loads digit k
- din  in  32  digit data; digit k = din[4k+3:4k]
- digit_sel  out  3  current scan index {Q2,Q1,Q0}, Q0 = LSB
- digit_out  out  4  register contents of the currently scanned digit
- com  out  8  active-low COM select; com[k] = 0 iff digit_sel == k (com[0] = COM1)
- seg_a  out  1  high iff digit_out[1:0] == 2'b01 (top)
- seg_g  out  1  high iff digit_out[1:0] == 2'b10 (middle)
- seg_d  out  1  high iff digit_out[1:0] == 2'b11 (bottom)

Behaviour:
- Reset (asynchronous, rst_n low, any time including mid-scan):
  - scan counter = 0, prescaler = 0, all eight digit registers = 4'h0.
  - Outputs while reset is held: digit_sel = 0, com = 8'b1111_1110, digit_out = 0, seg_a/g/d = 0.
- Scan counter:
  - 3-bit up counter with a prescaler.
  - On each rising clk, prescaler increments. When it equals SCAN_DIV-1, it clears and the counter increments.
  - With SCAN_DIV = 1, the counter increments every cycle.
  - Wraps 7 -> 0 with no gap or stall.
  - First advance after reset release: 0 -> 1 on the SCAN_DIV-th rising edge.
- Digit registers (eight identical 4-bit registers):
  - On rising clk: if ce[k] = 1, reg[k] <= din[4k+3:4k]; otherwise reg[k] holds.
  - Load latency is 1 cycle; new value is visible on digit_out from the cycle after the capturing edge.
  - Simultaneous ce on several digits loads all of them independently.
  - ce and din are ignored during reset.
- Selection:
  - Purely combinational 2:1 mux tree with 4-bit lanes; each 2:1 mux outputs s0 when its select = 0 and s1 when its select = 1.
  - Layer 1 is selected by Q0: pairs (0,1), (2,3), (4,5), (6,7).
  - Layer 2 is selected by Q1; layer 3 is selected by Q2.
  - Net result: digit_out = reg[digit_sel] in the same cycle as digit_sel, with no register stage.
- COM decode:
  - Combinational; exactly one bit low at all times, including during reset.
- Segment decode:
  - Combinational from digit_out[1:0]; digit_out[3:2] are ignored.
  - Code 00 lights no segment; at most one segment is high at a time.
- No output glitch is required beyond normal combinational settling; all outputs change only after the clk edge that alters the counter or the registers.

Test Plan:
- Reset: hold rst_n low 3 cycles with ce = 8'hFF and din = 32'hFFFF_FFFF -> digit_sel = 0, com = 8'hFE, digit_out = 0, all segs 0; release, and registers are still 0 until the first loading edge.
- Scan sequence (SCAN_DIV = 1): after reset, over 9 edges digit_sel = 1,2,...,7,0,1 and com walks FD, FB, F7, EF, DF, BF, 7F, FE, FD; SCAN_DIV = 3 -> each index held 3 cycles.
- Load and hold:
  - One cycle with ce = 8'hFF and din = 32'h7654_3210, then ce = 0 with din changed to 32'hAAAA_AAAA.
  - Over a full scan, digit_out equals digit_sel (0..7), i.e. the values are held.
- Selective enable: ce = 8'b0000_0100 with digit 2 = 4'h3, all other din = 4'h1 -> only reg[2] changes to 3; the others keep their prior values.
- Segment decode: digits loaded with 0,1,2,3,4,5,6,7 -> per index, (a,g,d) = 000, 100, 010, 001, 000, 100, 010, 001.
- Reset mid-scan: assert rst_n low while digit_sel = 5 -> immediately (without a clk edge) digit_sel = 0, com = FE, digit_out = 0; scanning resumes from 0 after release.
